muldiv_sequencer: RTL and testbench

Multi-cycle controller and iterative datapath for the RV32M operations that the decoder encodes on alu_ctl (codes 00010..01001). It accepts one operation at a time from the execute stage and runs it as a 32-step shift-add multiply or a restoring divide. While the operation runs it holds the core's PC and pipeline through stall, then returns a registered 32-bit result with a one-cycle done pulse. Single-cycle ALU ops never enter this block.

---
 rtl/muldiv_sequencer_if.sv | 24 ++
 rtl/muldiv_sequencer.sv | 173 +++++++++++++++++
 tb/tb_muldiv_sequencer.sv | 279 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/muldiv_sequencer_if.sv
// Request/response bundle between the execute stage and the RV32M sequencer.
// Latency: none, wires only.
// Backpressure: the sequencer drives stall; the requester holds start until it deasserts.
interface muldiv_sequencer_if;
    logic        start;
    logic [4:0]  alu_ctl;
    logic [31:0] op_a;
    logic [31:0] op_b;
    logic        flush;
    logic        stall;
    logic        busy;
    logic        done;
    logic [31:0] result;

    modport master (
        output start, alu_ctl, op_a, op_b, flush,
        input  stall, busy, done, result
    );

    modport slave (
        input  start, alu_ctl, op_a, op_b, flush,
        output stall, busy, done, result
    );
endinterface

// File: rtl/muldiv_sequencer.sv
// Iterative RV32M multiply/divide sequencer (shift-add multiply, restoring divide).
// Latency: done 33 cycles after accept, 1 cycle for divide-by-zero / signed overflow.
// Backpressure: stall holds the pipeline from accept through the last iteration; starts while busy are ignored.
module muldiv_sequencer #(
    parameter int XLEN = 32,
    parameter int ITER = 32
) (
    input  logic             clk,
    input  logic             rst,
    muldiv_sequencer_if.slave bus
);
    localparam int CW = $clog2(ITER);
    localparam logic [CW-1:0] LAST = CW'(ITER - 1);

    localparam logic [4:0] OP_MUL    = 5'b00010;
    localparam logic [4:0] OP_MULH   = 5'b00011;
    localparam logic [4:0] OP_MULHSU = 5'b00100;
    localparam logic [4:0] OP_MULHU  = 5'b00101;
    localparam logic [4:0] OP_DIV    = 5'b00110;
    localparam logic [4:0] OP_DIVU   = 5'b00111;
    localparam logic [4:0] OP_REM    = 5'b01000;
    localparam logic [4:0] OP_REMU   = 5'b01001;

    typedef enum logic [1:0] {S_IDLE, S_CALC, S_DONE} state_t;

    state_t              r_state;
    logic [CW-1:0]       r_cnt;
    logic [4:0]          r_op;
    logic                r_neg;      // product / quotient needs negation
    logic                r_rneg;     // remainder takes the dividend's sign
    logic [2*XLEN-1:0]   r_acc;      // product accumulator
    logic [2*XLEN-1:0]   r_mcand;    // multiplicand, shifted left each step
    logic [XLEN-1:0]     r_mplier;   // multiplier, shifted right each step
    logic [XLEN-1:0]     r_rem;      // partial remainder
    logic [XLEN-1:0]     r_quo;      // dividend shifts out, quotient shifts in
    logic [XLEN-1:0]     r_dvsr;
    logic [XLEN-1:0]     r_result;
    logic [XLEN-1:0]     r_prev;     // result before the last load, restored on flush in DONE
    logic                r_done;

    logic                w_code_ok;
    logic                w_is_div;
    logic                w_a_neg;
    logic                w_b_neg;
    logic [XLEN-1:0]     w_mag_a;
    logic [XLEN-1:0]     w_mag_b;
    logic                w_div0;
    logic                w_ovf;
    logic [XLEN-1:0]     w_fast_res;
    logic                w_accept;
    logic [2*XLEN-1:0]   w_acc_nx;
    logic [XLEN:0]       w_rem_sh;
    logic                w_qbit;
    logic [XLEN-1:0]     w_rem_nx;
    logic [XLEN-1:0]     w_quo_nx;
    logic [2*XLEN-1:0]   w_prod;
    logic [XLEN-1:0]     w_calc_res;

    // Decode the incoming request: validity, signedness, magnitudes and fast-path cases.
    always_comb begin
        w_code_ok = bus.alu_ctl inside {[OP_MUL:OP_REMU]};
        w_is_div  = bus.alu_ctl inside {OP_DIV, OP_DIVU, OP_REM, OP_REMU};
        w_a_neg   = (bus.alu_ctl inside {OP_MULH, OP_MULHSU, OP_DIV, OP_REM}) & bus.op_a[XLEN-1];
        w_b_neg   = (bus.alu_ctl inside {OP_MULH, OP_DIV, OP_REM}) & bus.op_b[XLEN-1];
        w_mag_a   = w_a_neg ? -bus.op_a : bus.op_a;
        w_mag_b   = w_b_neg ? -bus.op_b : bus.op_b;
        w_div0    = w_is_div & (bus.op_b == '0);
        w_ovf     = (bus.alu_ctl inside {OP_DIV, OP_REM}) &
                    (bus.op_a == {1'b1, {(XLEN-1){1'b0}}}) & (bus.op_b == '1);
        w_fast_res = '0;
        if (w_div0)
            w_fast_res = (bus.alu_ctl inside {OP_DIV, OP_DIVU}) ? '1 : bus.op_a;
        else if (w_ovf)
            w_fast_res = (bus.alu_ctl == OP_DIV) ? {1'b1, {(XLEN-1){1'b0}}} : '0;
        // flush wins over start in IDLE
        w_accept  = (r_state == S_IDLE) & bus.start & w_code_ok & ~bus.flush;
    end

    // One multiply step and one restoring-divide step, plus sign-corrected final result.
    always_comb begin
        w_acc_nx = r_mplier[0] ? (r_acc + r_mcand) : r_acc;
        w_rem_sh = {r_rem, r_quo[XLEN-1]};
        w_qbit   = (w_rem_sh >= {1'b0, r_dvsr});
        // when the trial subtraction succeeds the difference fits in XLEN bits
        w_rem_nx = w_qbit ? (w_rem_sh[XLEN-1:0] - r_dvsr) : w_rem_sh[XLEN-1:0];
        w_quo_nx = {r_quo[XLEN-2:0], w_qbit};
        w_prod   = r_neg ? -w_acc_nx : w_acc_nx;
        case (r_op)
            OP_MUL:                         w_calc_res = w_prod[XLEN-1:0];
            OP_MULH, OP_MULHSU, OP_MULHU:   w_calc_res = w_prod[2*XLEN-1:XLEN];
            OP_DIV, OP_DIVU:                w_calc_res = r_neg ? -w_quo_nx : w_quo_nx;
            default:                        w_calc_res = r_rneg ? -w_rem_nx : w_rem_nx;
        endcase
    end

    // Sequencer FSM and datapath registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state  <= S_IDLE;
            r_cnt    <= '0;
            r_op     <= '0;
            r_neg    <= 1'b0;
            r_rneg   <= 1'b0;
            r_acc    <= '0;
            r_mcand  <= '0;
            r_mplier <= '0;
            r_rem    <= '0;
            r_quo    <= '0;
            r_dvsr   <= '0;
            r_result <= '0;
            r_prev   <= '0;
            r_done   <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_op     <= bus.alu_ctl;
                        r_cnt    <= '0;
                        r_neg    <= w_a_neg ^ w_b_neg;
                        r_rneg   <= w_a_neg;
                        r_acc    <= '0;
                        r_mcand  <= {{XLEN{1'b0}}, w_mag_a};
                        r_mplier <= w_mag_b;
                        r_rem    <= '0;
                        r_quo    <= w_mag_a;
                        r_dvsr   <= w_mag_b;
                        if (w_div0 | w_ovf) begin
                            r_prev   <= r_result;
                            r_result <= w_fast_res;
                            r_done   <= 1'b1;
                            r_state  <= S_DONE;
                        end else begin
                            r_state  <= S_CALC;
                        end
                    end
                end
                S_CALC: begin
                    if (bus.flush) begin
                        r_state <= S_IDLE;
                    end else begin
                        r_acc    <= w_acc_nx;
                        r_mcand  <= {r_mcand[2*XLEN-2:0], 1'b0};
                        r_mplier <= {1'b0, r_mplier[XLEN-1:1]};
                        r_rem    <= w_rem_nx;
                        r_quo    <= w_quo_nx;
                        r_cnt    <= r_cnt + 1'b1;
                        if (r_cnt == LAST) begin
                            r_prev   <= r_result;
                            r_result <= w_calc_res;
                            r_done   <= 1'b1;
                            r_state  <= S_DONE;
                        end
                    end
                end
                S_DONE: begin
                    r_state <= S_IDLE;
                    if (bus.flush)
                        r_result <= r_prev;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    // Status outputs; a flush in the DONE cycle suppresses the pulse.
    always_comb begin
        bus.stall  = ~rst & (w_accept | (r_state == S_CALC));
        bus.busy   = (r_state != S_IDLE);
        bus.done   = r_done & ~bus.flush;
        bus.result = r_result;
    end
endmodule

// File: tb/tb_muldiv_sequencer.sv
// Scoreboard bench for muldiv_sequencer: directed corners plus randomized ops vs an arithmetic model.
// Latency: checks done cycle against accept+33 (accept+1 for fast paths).
// Backpressure: driver waits for busy=0 before presenting each request.
module tb_muldiv_sequencer;
    logic clk = 1'b0;
    logic rst = 1'b1;

    muldiv_sequencer_if bus();

    muldiv_sequencer #(.XLEN(32), .ITER(32)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    localparam logic [4:0] MUL = 5'd2, MULH = 5'd3, MULHSU = 5'd4, MULHU = 5'd5;
    localparam logic [4:0] DIV = 5'd6, DIVU = 5'd7, REM = 5'd8, REMU = 5'd9;

    typedef struct {
        logic [31:0] res;
        int          cyc;
        int          id;
    } exp_t;

    exp_t        sbq[$];
    int          n_pass = 0;
    int          n_tot  = 0;
    int          n_id   = 0;
    logic [31:0] last_res = 32'h0;

    task automatic check(input string nm, input logic [31:0] got, input logic [31:0] want);
        n_tot++;
        if (got === want) n_pass++;
        else $display("FAIL %s: got %h want %h", nm, got, want);
    endtask

    // Reference arithmetic straight from the RV32M definitions.
    function automatic logic [31:0] ref_res(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b);
        int          ia, ib;
        longint      la, lb, lub, ps;
        logic [63:0] pu;
        ia  = a;
        ib  = b;
        la  = ia;
        lb  = ib;
        lub = longint'({32'h0, b});
        pu  = {32'h0, a} * {32'h0, b};
        case (op)
            MUL:    return pu[31:0];
            MULH:   begin ps = la * lb;  return ps[63:32]; end
            MULHSU: begin ps = la * lub; return ps[63:32]; end
            MULHU:  return pu[63:32];
            DIV:    begin
                        if (b == 0) return 32'hFFFFFFFF;
                        if (a == 32'h80000000 && b == 32'hFFFFFFFF) return 32'h80000000;
                        return 32'(ia / ib);
                    end
            DIVU:   return (b == 0) ? 32'hFFFFFFFF : a / b;
            REM:    begin
                        if (b == 0) return a;
                        if (a == 32'h80000000 && b == 32'hFFFFFFFF) return 32'h0;
                        return 32'(ia % ib);
                    end
            REMU:   return (b == 0) ? a : a % b;
            default: return 32'h0;
        endcase
    endfunction

    function automatic bit is_fast(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b);
        if (op inside {DIV, DIVU, REM, REMU} && b == 0) return 1'b1;
        if (op inside {DIV, REM} && a == 32'h80000000 && b == 32'hFFFFFFFF) return 1'b1;
        return 1'b0;
    endfunction

    function automatic logic [31:0] pick();
        case ($urandom % 6)
            0: return 32'h0;
            1: return 32'hFFFFFFFF;
            2: return 32'h80000000;
            3: return 32'($urandom % 16);
            default: return 32'($urandom);
        endcase
    endfunction

    // Monitor: pop and compare on every done pulse.
    exp_t mon_e;
    initial begin
        forever begin
            @(negedge clk);
            #2;
            if (bus.done === 1'b1) begin
                if (sbq.size() == 0) begin
                    n_tot++;
                    $display("FAIL unexpected_done: got done at cycle %0d want none", cyc);
                end else begin
                    mon_e = sbq.pop_front();
                    check($sformatf("result_op%0d", mon_e.id), bus.result, mon_e.res);
                    check($sformatf("done_cycle_op%0d", mon_e.id), 32'(cyc), 32'(mon_e.cyc));
                    check($sformatf("stall_at_done_op%0d", mon_e.id), {31'b0, bus.stall}, 32'd0);
                end
            end
        end
    end

    task automatic wait_idle();
        int k;
        k = 0;
        while (bus.busy !== 1'b0 && k < 300) begin
            @(negedge clk);
            k++;
        end
        if (k >= 300) begin
            n_tot++;
            $display("FAIL idle_timeout: busy %b want 0", bus.busy);
        end
    endtask

    // Present one request for a single cycle; returns the accept cycle.
    task automatic issue(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b,
                         input bit push, output int t);
        logic [31:0] r;
        @(negedge clk);
        wait_idle();
        bus.start   = 1'b1;
        bus.alu_ctl = op;
        bus.op_a    = a;
        bus.op_b    = b;
        t = cyc;
        if (push) begin
            r = ref_res(op, a, b);
            sbq.push_back('{r, t + (is_fast(op, a, b) ? 1 : 33), n_id});
            n_id++;
            last_res = r;
        end
        #1 check("stall_on_accept", {31'b0, bus.stall}, 32'd1);
        @(negedge clk);
        bus.start   = 1'b0;
        bus.alu_ctl = 5'($urandom);
        bus.op_a    = $urandom;
        bus.op_b    = $urandom;
    endtask

    logic [4:0]  d_op[14] = '{MUL, MULHU, MULH, MULHSU, MULHU, DIV, REM, DIVU, REMU,
                              DIVU, REMU, DIV, REM, MUL};
    logic [31:0] d_a[14]  = '{32'd7, 32'd7, 32'h80000000, 32'hFFFFFFFF, 32'hFFFFFFFF,
                              32'hFFFFFFF9, 32'hFFFFFFF9, 32'd100, 32'd100,
                              32'd5, 32'd5, 32'h80000000, 32'h80000000, 32'h12345678};
    logic [31:0] d_b[14]  = '{32'hFFFFFFFD, 32'hFFFFFFFD, 32'h80000000, 32'hFFFFFFFF, 32'hFFFFFFFF,
                              32'd2, 32'd2, 32'd7, 32'd7,
                              32'd0, 32'd0, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h9ABCDEF0};
    logic [4:0]  bad_codes[4] = '{5'd0, 5'd1, 5'd10, 5'd31};

    initial begin
        int t;
        int nst;
        bus.start   = 1'b0;
        bus.alu_ctl = 5'd0;
        bus.op_a    = 32'h0;
        bus.op_b    = 32'h0;
        bus.flush   = 1'b0;

        // Reset state
        repeat (2) @(negedge clk);
        #1;
        check("rst_stall",  {31'b0, bus.stall}, 32'd0);
        check("rst_busy",   {31'b0, bus.busy},  32'd0);
        check("rst_done",   {31'b0, bus.done},  32'd0);
        check("rst_result", bus.result,         32'd0);
        @(negedge clk);
        rst = 1'b0;

        // First op: count stall cycles T+1..T+32 as well
        issue(d_op[0], d_a[0], d_b[0], 1'b1, t);
        nst = 0;
        for (int i = 0; i < 32; i++) begin
            #1 if (bus.stall === 1'b1) nst++;
            @(negedge clk);
        end
        check("stall_cycles_mul", 32'(nst), 32'd32);

        // Directed corners
        for (int i = 1; i < 14; i++) issue(d_op[i], d_a[i], d_b[i], 1'b1, t);

        // Flush during divide at T+10
        issue(DIV, 32'd1000, 32'd3, 1'b0, t);
        while (cyc < t + 10) @(negedge clk);
        bus.flush = 1'b1;
        @(negedge clk);
        bus.flush = 1'b0;
        #1;
        check("flush_busy",   {31'b0, bus.busy}, 32'd0);
        check("flush_result", bus.result, last_res);
        repeat (40) @(negedge clk);
        check("flush_result_held", bus.result, last_res);

        // Reset mid-operation at T+5
        issue(MUL, 32'd3, 32'd5, 1'b0, t);
        while (cyc < t + 5) @(negedge clk);
        rst = 1'b1;
        #1;
        check("midrst_stall",  {31'b0, bus.stall}, 32'd0);
        check("midrst_busy",   {31'b0, bus.busy},  32'd0);
        check("midrst_done",   {31'b0, bus.done},  32'd0);
        check("midrst_result", bus.result,         32'd0);
        last_res = 32'h0;
        @(negedge clk);
        rst = 1'b0;

        // Invalid codes are ignored
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            bus.start   = 1'b1;
            bus.alu_ctl = bad_codes[i];
            bus.op_a    = 32'd9;
            bus.op_b    = 32'd3;
            #1 check($sformatf("invalid_stall_%0d", bad_codes[i]), {31'b0, bus.stall}, 32'd0);
            @(negedge clk);
            bus.start = 1'b0;
            #1 check($sformatf("invalid_busy_%0d", bad_codes[i]), {31'b0, bus.busy}, 32'd0);
        end
        repeat (5) @(negedge clk);

        // Back-to-back with start held: mul, then divu accepted the cycle after done
        @(negedge clk);
        wait_idle();
        bus.start   = 1'b1;
        bus.alu_ctl = MUL;
        bus.op_a    = 32'd7;
        bus.op_b    = 32'hFFFFFFFD;
        t = cyc;
        sbq.push_back('{ref_res(MUL, 32'd7, 32'hFFFFFFFD), t + 33, n_id});
        n_id++;
        sbq.push_back('{ref_res(DIVU, 32'd100, 32'd7), t + 67, n_id});
        n_id++;
        last_res = ref_res(DIVU, 32'd100, 32'd7);
        @(negedge clk);
        bus.alu_ctl = DIVU;
        bus.op_a    = 32'd100;
        bus.op_b    = 32'd7;
        while (cyc < t + 33) @(negedge clk);
        #1 check("b2b_stall_in_done", {31'b0, bus.stall}, 32'd0);
        @(negedge clk);
        #1 check("b2b_stall_on_reaccept", {31'b0, bus.stall}, 32'd1);
        @(negedge clk);
        bus.start = 1'b0;

        // Randomized ops
        for (int i = 0; i < 40; i++) begin
            logic [4:0]  op;
            logic [31:0] a, b;
            op = 5'(2 + ($urandom % 8));
            a  = pick();
            b  = pick();
            issue(op, a, b, 1'b1, t);
        end

        // Drain the scoreboard
        begin
            int k;
            k = 0;
            while (sbq.size() > 0 && k < 200) begin
                @(negedge clk);
                k++;
            end
            if (sbq.size() > 0) begin
                n_tot++;
                $display("FAIL drain: got %0d pending want 0", sbq.size());
            end
        end
        repeat (3) @(negedge clk);
        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end
endmodule
